depth_test: RTL and testbench

Parametrised, pipelined per-pixel depth-test unit: the successor to the single-resolution 8-bit z-buffer. Sits between the triangle rasterizer and the framebuffer pixel writer. It accepts one fragment per cycle, tests its screen-space z against an internal depth RAM, updates the RAM, and emits surviving fragments. It owns its own clear sequencer, so the RAM needs no init file.

---
 rtl/depth_pkg.sv | 29 ++
 rtl/depth_test_if.sv | 32 +++
 rtl/depth_ram.sv | 23 ++
 rtl/depth_test.sv | 173 +++++++++++++++++
 tb/tb_depth_test.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/depth_pkg.sv
// Shared types for the pipelined per-pixel depth-test unit.
package depth_pkg;

  typedef enum logic [1:0] {
    LESS   = 2'd0,
    LEQUAL = 2'd1,
    ALWAYS = 2'd2,
    NEVER  = 2'd3
  } cmp_mode_e;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Depth function outcome from the z<stored and z==stored relations.
  function automatic logic depth_pass(cmp_mode_e mode, logic lt, logic eq);
    logic p;
    case (mode)
      LESS:    p = lt;
      LEQUAL:  p = lt | eq;
      ALWAYS:  p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/depth_test_if.sv
// Fragment-in / surviving-fragment-out bus of the depth-test unit.
interface depth_test_if import depth_pkg::*; #(
  parameter int unsigned X_W = 9,
  parameter int unsigned Y_W = 8,
  parameter int unsigned Z_W = 16
) ();

  logic           frag_valid;
  logic           frag_ready;
  logic [X_W-1:0] frag_x;
  logic [Y_W-1:0] frag_y;
  logic [Z_W-1:0] frag_z;
  cmp_mode_e      cmp_mode;
  logic           z_write_en;
  logic           clear_start;
  logic           busy;
  logic           pass_valid;
  logic [X_W-1:0] pass_x;
  logic [Y_W-1:0] pass_y;
  logic [Z_W-1:0] pass_z;

  modport master (
    output frag_valid, frag_x, frag_y, frag_z, cmp_mode, z_write_en, clear_start,
    input  frag_ready, busy, pass_valid, pass_x, pass_y, pass_z
  );

  modport slave (
    input  frag_valid, frag_x, frag_y, frag_z, cmp_mode, z_write_en, clear_start,
    output frag_ready, busy, pass_valid, pass_x, pass_y, pass_z
  );

endinterface

// File: rtl/depth_ram.sv
// Simple dual-port depth RAM: one write port, one registered read port.
module depth_ram #(
  parameter int unsigned DEPTH  = 76800,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/depth_test.sv
// Pipelined z-test: accept, RAM read, compare/update, registered pass output.
// Owns a clear sequencer that sweeps the RAM to the far plane.
module depth_test import depth_pkg::*; #(
  parameter int unsigned H_RES = 320,
  parameter int unsigned V_RES = 240,
  parameter int unsigned Z_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  depth_test_if.slave  bus
);

  localparam int unsigned DEPTH  = H_RES * V_RES;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned X_W    = $clog2(H_RES);
  localparam int unsigned Y_W    = $clog2(V_RES);
  localparam logic [Z_W-1:0] Z_MAX = '1;

  state_e            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              frag_ready_q;
  logic              busy_q;

  logic              accept_c;
  logic              in_range_c;
  logic [ADDR_W-1:0] addr_c;

  logic              s1_valid;
  logic [X_W-1:0]    s1_x;
  logic [Y_W-1:0]    s1_y;
  logic [Z_W-1:0]    s1_z;
  logic [ADDR_W-1:0] s1_addr;
  cmp_mode_e         s1_mode;
  logic              s1_wen;
  logic              s1_in_range;

  logic              last_wvalid;
  logic [ADDR_W-1:0] last_waddr;
  logic [Z_W-1:0]    last_wdata;

  logic [Z_W-1:0]    ram_dout;
  logic [Z_W-1:0]    stored_c;
  logic              pass_c;
  logic              s1_write_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_waddr_c;
  logic [Z_W-1:0]    ram_wdata_c;

  logic              pass_valid_q;
  logic [X_W-1:0]    pass_x_q;
  logic [Y_W-1:0]    pass_y_q;
  logic [Z_W-1:0]    pass_z_q;

  // Stage 0: accept and address generation at full address width.
  assign accept_c   = bus.frag_valid & frag_ready_q;
  assign in_range_c = (32'(bus.frag_x) < H_RES) && (32'(bus.frag_y) < V_RES);
  assign addr_c     = ADDR_W'(bus.frag_y) * ADDR_W'(H_RES) + ADDR_W'(bus.frag_x);

  // Stage 1: a write last cycle to the same pixel is newer than the RAM output.
  assign stored_c   = (last_wvalid && (last_waddr == s1_addr)) ? last_wdata : ram_dout;
  assign pass_c     = s1_valid && s1_in_range &&
                      depth_pass(s1_mode, s1_z < stored_c, s1_z == stored_c);
  assign s1_write_c = pass_c & s1_wen;

  // Clear sequencer owns the write port while sweeping.
  always_comb begin
    ram_we_c    = s1_write_c;
    ram_waddr_c = s1_addr;
    ram_wdata_c = s1_z;
    if (state == CLEAR) begin
      ram_we_c    = 1'b1;
      ram_waddr_c = clr_cnt;
      ram_wdata_c = Z_MAX;
    end
  end

  depth_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (Z_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .waddr (ram_waddr_c),
    .wdata (ram_wdata_c),
    .re    (accept_c & in_range_c),
    .raddr (addr_c),
    .rdata (ram_dout)
  );

  // Clear / run / drain control with registered ready and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      frag_ready_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state        <= RUN;
            clr_cnt      <= '0;
            frag_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        RUN: begin
          if (bus.clear_start) begin
            state        <= DRAIN;
            frag_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        default: begin
          state        <= CLEAR;
          clr_cnt      <= '0;
          frag_ready_q <= 1'b0;
          busy_q       <= 1'b1;
        end
      endcase
    end
  end

  // Pipeline registers, write-forwarding record and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      last_wvalid  <= 1'b0;
      pass_valid_q <= 1'b0;
      pass_x_q     <= '0;
      pass_y_q     <= '0;
      pass_z_q     <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_x        <= bus.frag_x;
        s1_y        <= bus.frag_y;
        s1_z        <= bus.frag_z;
        s1_addr     <= addr_c;
        s1_mode     <= bus.cmp_mode;
        s1_wen      <= bus.z_write_en;
        s1_in_range <= in_range_c;
      end
      last_wvalid <= s1_write_c;
      if (s1_write_c) begin
        last_waddr <= s1_addr;
        last_wdata <= s1_z;
      end
      pass_valid_q <= pass_c;
      if (pass_c) begin
        pass_x_q <= s1_x;
        pass_y_q <= s1_y;
        pass_z_q <= s1_z;
      end
    end
  end

  assign bus.frag_ready = frag_ready_q;
  assign bus.busy       = busy_q;
  assign bus.pass_valid = pass_valid_q;
  assign bus.pass_x     = pass_x_q;
  assign bus.pass_y     = pass_y_q;
  assign bus.pass_z     = pass_z_q;

endmodule

// File: tb/tb_depth_test.sv
// Self-checking bench for depth_test at a reduced 40x30 resolution.
module tb_depth_test;
  import depth_pkg::*;

  localparam int unsigned H_RES = 40;
  localparam int unsigned V_RES = 30;
  localparam int unsigned Z_W   = 16;
  localparam int unsigned DEPTH = H_RES * V_RES;
  localparam int unsigned X_W   = $clog2(H_RES);
  localparam int unsigned Y_W   = $clog2(V_RES);
  localparam int          Z_MAX = (1 << Z_W) - 1;

  typedef struct {
    int due;
    int x;
    int y;
    int z;
  } exp_t;

  typedef struct {
    int        x;
    int        y;
    int        z;
    cmp_mode_e m;
    bit        wen;
    bit        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  bit   mon_en = 1'b0;
  bit   mon_exp_now;
  exp_t mon_e;

  int   ref_z [DEPTH];
  exp_t exp_q [$];

  depth_test_if #(.X_W(X_W), .Y_W(Y_W), .Z_W(Z_W)) bus ();

  depth_test #(.H_RES(H_RES), .V_RES(V_RES), .Z_W(Z_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  // Reference: fragments resolve strictly in acceptance order against a plain depth array.
  function automatic void model_clear_ram();
    for (int i = 0; i < int'(DEPTH); i++) ref_z[i] = Z_MAX;
  endfunction

  function automatic void model_frag(int x, int y, int z, cmp_mode_e m, bit wen);
    int  idx;
    bit  p;
    if (x >= int'(H_RES) || y >= int'(V_RES)) return;
    idx = y * int'(H_RES) + x;
    case (m)
      LESS:    p = (z <  ref_z[idx]);
      LEQUAL:  p = (z <= ref_z[idx]);
      ALWAYS:  p = 1'b1;
      default: p = 1'b0;
    endcase
    if (p) begin
      if (wen) ref_z[idx] = z;
      exp_q.push_back('{ncyc + 2, x, y, z});
    end
  endfunction

  task automatic send_frag(int x, int y, int z, cmp_mode_e m, bit wen, bit clr);
    bus.frag_valid  = 1'b1;
    bus.frag_x      = X_W'(x);
    bus.frag_y      = Y_W'(y);
    bus.frag_z      = Z_W'(z);
    bus.cmp_mode    = m;
    bus.z_write_en  = wen;
    bus.clear_start = clr;
    if (bus.frag_ready === 1'b1) begin
      model_frag(x, y, z, m, wen);
      if (clr) model_clear_ram();
    end
    @(posedge clk); #1;
    bus.frag_valid  = 1'b0;
    bus.clear_start = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard on the pass stream, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].due < ncyc) void'(exp_q.pop_front());
      mon_exp_now = (exp_q.size() > 0) && (exp_q[0].due == ncyc);
      checks++;
      if (bus.pass_valid !== mon_exp_now) begin
        errors++;
        $display("FAIL pass_valid @cyc %0d: got %b expected %b", ncyc, bus.pass_valid, mon_exp_now);
      end
      if (mon_exp_now) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (bus.pass_x !== X_W'(mon_e.x) || bus.pass_y !== Y_W'(mon_e.y) || bus.pass_z !== Z_W'(mon_e.z)) begin
          errors++;
          $display("FAIL pass_xyz @cyc %0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", ncyc,
                   bus.pass_x, bus.pass_y, bus.pass_z, mon_e.x, mon_e.y, mon_e.z);
        end
      end
    end
  end

  task automatic test_reset();
    int n;
    bit early;
    mon_en = 1'b0;
    rst = 1'b1;
    bus.frag_valid = 1'b1; bus.frag_x = X_W'(1); bus.frag_y = Y_W'(1); bus.frag_z = '0;
    bus.cmp_mode = LESS; bus.z_write_en = 1'b1; bus.clear_start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bus.frag_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.frag_ready); end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
    checks++;
    if (bus.pass_valid !== 1'b0) begin errors++; $display("FAIL reset_pass_valid: got %b expected 0", bus.pass_valid); end
    checks++;
    if (bus.pass_x !== '0 || bus.pass_y !== '0 || bus.pass_z !== '0) begin
      errors++; $display("FAIL reset_pass_xyz: got (%0d,%0d,%0d) expected (0,0,0)", bus.pass_x, bus.pass_y, bus.pass_z);
    end
    rst = 1'b0;
    model_clear_ram();
    exp_q.delete();
    mon_en = 1'b1;
    n = 0; early = 1'b0;
    while (bus.busy === 1'b1 && n < int'(DEPTH) + 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.busy === 1'b1 && bus.frag_ready !== 1'b0) early = 1'b1;
    end
    bus.frag_valid = 1'b0;
    checks++;
    if (n != int'(DEPTH)) begin errors++; $display("FAIL clear_length: got %0d cycles expected %0d", n, DEPTH); end
    checks++;
    if (early) begin errors++; $display("FAIL ready_during_clear: got 1 expected 0"); end
    checks++;
    if (bus.frag_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clear: got %b expected 1", bus.frag_ready); end
  endtask

  task automatic test_first();
    send_frag(0, 0, Z_MAX - 1, LESS, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (bus.pass_valid !== 1'b1 || bus.pass_z !== Z_W'(Z_MAX - 1)) begin
      errors++; $display("FAIL first_vs_zmax: got v=%b z=%0d expected v=1 z=%0d", bus.pass_valid, bus.pass_z, Z_MAX - 1);
    end
    idle(2);
  endtask

  task automatic test_modes();
    vec_t v[7];
    v = '{'{10, 20, 100, LESS,   1'b1, 1'b1},
          '{10, 20, 100, LESS,   1'b1, 1'b0},
          '{10, 20, 100, LEQUAL, 1'b1, 1'b1},
          '{10, 20, 5,   NEVER,  1'b1, 1'b0},
          '{10, 20, 900, ALWAYS, 1'b1, 1'b1},
          '{10, 20, 900, LESS,   1'b0, 1'b0},
          '{10, 20, 899, LESS,   1'b0, 1'b1}};
    foreach (v[i]) begin
      send_frag(v[i].x, v[i].y, v[i].z, v[i].m, v[i].wen, 1'b0);
      checks++;
      if (bus.pass_valid !== 1'b0) begin errors++; $display("FAIL modes[%0d]_t1: got %b expected 0", i, bus.pass_valid); end
      @(posedge clk); #1;
      checks++;
      if (bus.pass_valid !== v[i].exp || (v[i].exp && bus.pass_z !== Z_W'(v[i].z))) begin
        errors++; $display("FAIL modes[%0d]_t2: got v=%b z=%0d expected v=%b z=%0d", i, bus.pass_valid, bus.pass_z, v[i].exp, v[i].z);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[2];
    send_frag(7, 7, 50, LESS, 1'b1, 1'b0);
    send_frag(7, 7, 40, LESS, 1'b1, 1'b0);
    checks++;
    if (bus.pass_valid !== 1'b1 || bus.pass_z !== Z_W'(50)) begin
      errors++; $display("FAIL b2b_first: got v=%b z=%0d expected v=1 z=50", bus.pass_valid, bus.pass_z);
    end
    send_frag(7, 7, 45, LESS, 1'b1, 1'b0);
    checks++;
    if (bus.pass_valid !== 1'b1 || bus.pass_z !== Z_W'(40)) begin
      errors++; $display("FAIL b2b_second: got v=%b z=%0d expected v=1 z=40", bus.pass_valid, bus.pass_z);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.pass_valid !== 1'b0) begin errors++; $display("FAIL b2b_third: got %b expected 0", bus.pass_valid); end
    v = '{'{7, 7, 40, LEQUAL, 1'b0, 1'b1},
          '{7, 7, 40, LESS,   1'b0, 1'b0}};
    foreach (v[i]) begin
      send_frag(v[i].x, v[i].y, v[i].z, v[i].m, v[i].wen, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.pass_valid !== v[i].exp) begin
        errors++; $display("FAIL b2b_probe[%0d]: got %b expected %b", i, bus.pass_valid, v[i].exp);
      end
    end
  endtask

  task automatic test_no_write();
    vec_t v[3];
    v = '{'{12, 5, 100, ALWAYS, 1'b1, 1'b1},
          '{12, 5, 10,  LESS,   1'b0, 1'b1},
          '{12, 5, 50,  LESS,   1'b1, 1'b1}};
    foreach (v[i]) begin
      send_frag(v[i].x, v[i].y, v[i].z, v[i].m, v[i].wen, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.pass_valid !== v[i].exp || (v[i].exp && bus.pass_z !== Z_W'(v[i].z))) begin
        errors++; $display("FAIL nowrite[%0d]: got v=%b z=%0d expected v=%b z=%0d", i, bus.pass_valid, bus.pass_z, v[i].exp, v[i].z);
      end
    end
  endtask

  task automatic test_out_of_range();
    vec_t v[11];
    v = '{'{0,  0,  500, ALWAYS, 1'b1, 1'b1},
          '{39, 29, 600, ALWAYS, 1'b1, 1'b1},
          '{0,  1,  700, ALWAYS, 1'b1, 1'b1},
          '{40, 0,  3,   ALWAYS, 1'b1, 1'b0},
          '{0,  30, 3,   ALWAYS, 1'b1, 1'b0},
          '{63, 31, 3,   ALWAYS, 1'b1, 1'b0},
          '{0,  0,  500, LEQUAL, 1'b0, 1'b1},
          '{0,  0,  500, LESS,   1'b0, 1'b0},
          '{39, 29, 600, LEQUAL, 1'b0, 1'b1},
          '{39, 29, 600, LESS,   1'b0, 1'b0},
          '{0,  1,  700, LEQUAL, 1'b0, 1'b1}};
    foreach (v[i]) begin
      checks++;
      if (bus.frag_ready !== 1'b1) begin errors++; $display("FAIL oor_ready[%0d]: got %b expected 1", i, bus.frag_ready); end
      send_frag(v[i].x, v[i].y, v[i].z, v[i].m, v[i].wen, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.pass_valid !== v[i].exp) begin
        errors++; $display("FAIL oor[%0d]: got %b expected %b", i, bus.pass_valid, v[i].exp);
      end
    end
  endtask

  task automatic test_clear_midstream();
    int   n;
    vec_t v[2];
    for (int i = 0; i < 6; i++) begin
      send_frag(3, 3, int'($urandom_range(1000, 10)), LESS, 1'b1, i == 3);
      if (i == 3) begin
        checks++;
        if (bus.frag_ready !== 1'b0 || bus.busy !== 1'b1) begin
          errors++; $display("FAIL drain_entry: got ready=%b busy=%b expected ready=0 busy=1", bus.frag_ready, bus.busy);
        end
      end
    end
    n = 0;
    while (bus.busy === 1'b1 && n < int'(DEPTH) + 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n + 2 < int'(DEPTH) + 1 || n + 2 > int'(DEPTH) + 2) begin
      errors++; $display("FAIL clear_busy_span: got %0d expected %0d..%0d", n + 2, DEPTH + 1, DEPTH + 2);
    end
    checks++;
    if (bus.frag_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reclear: got %b expected 1", bus.frag_ready); end
    v = '{'{3, 3, Z_MAX,     LESS, 1'b0, 1'b0},
          '{3, 3, Z_MAX - 1, LESS, 1'b0, 1'b1}};
    foreach (v[i]) begin
      send_frag(v[i].x, v[i].y, v[i].z, v[i].m, v[i].wen, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.pass_valid !== v[i].exp) begin
        errors++; $display("FAIL cleared_pixel[%0d]: got %b expected %b", i, bus.pass_valid, v[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int   n;
    vec_t v[2];
    bus.clear_start = 1'b1;
    @(posedge clk); #1;
    bus.clear_start = 1'b0;
    model_clear_ram();
    idle(100);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < int'(DEPTH) + 50) begin
      bus.clear_start = (n == 10);
      @(posedge clk); #1;
      n++;
    end
    bus.clear_start = 1'b0;
    checks++;
    if (n != int'(DEPTH)) begin errors++; $display("FAIL restart_sweep: got %0d cycles expected %0d", n, DEPTH); end
    v = '{'{10, 20, Z_MAX,     LESS, 1'b0, 1'b0},
          '{10, 20, Z_MAX - 1, LESS, 1'b0, 1'b1}};
    foreach (v[i]) begin
      send_frag(v[i].x, v[i].y, v[i].z, v[i].m, v[i].wen, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.pass_valid !== v[i].exp) begin
        errors++; $display("FAIL post_reset_pixel[%0d]: got %b expected %b", i, bus.pass_valid, v[i].exp);
      end
    end
  endtask

  task automatic test_random();
    int x, y, z, sel;
    for (int i = 0; i < 400; i++) begin
      x   = int'($urandom_range(0, 41));
      y   = ($urandom_range(0, 15) == 0) ? 30 : int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      z   = (sel == 0) ? 0 : (sel == 1) ? Z_MAX : int'($urandom_range(0, 400));
      send_frag(x, y, z, cmp_mode_e'(2'($urandom_range(0, 3))), $urandom_range(0, 3) != 0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL random_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    bus.frag_valid = 1'b0; bus.frag_x = '0; bus.frag_y = '0; bus.frag_z = '0;
    bus.cmp_mode = LESS; bus.z_write_en = 1'b0; bus.clear_start = 1'b0;
    test_reset();
    test_first();
    test_modes();
    test_back_to_back();
    test_no_write();
    test_out_of_range();
    test_clear_midstream();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout: simulation did not complete within 100000 cycles");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
